// File: rtl/dp_sched_pkg.sv
// rtl/dp_sched_pkg.sv - shared state encoding, id width and chunk-count helper
package dp_sched_pkg;

  localparam int ID_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-input round-robin arbiter; on contention the
// requester that did not win last time is granted.
module rr_arbiter_2
  import dp_sched_pkg::*;
(
  input  logic [1:0]      i_req,
  input  logic [ID_W-1:0] i_last_grant,
  output logic            o_grant_valid,
  output logic [ID_W-1:0] o_grant_id
);

  always_comb begin
    o_grant_valid = |i_req;
    o_grant_id    = i_req[1] ? 1'b1 : 1'b0;
    if (&i_req) o_grant_id = ~i_last_grant;
  end

endmodule

// File: rtl/dot_product_scheduler.sv
// rtl/dot_product_scheduler.sv - shares one dot-product unit between the r.r and
// p.Ap requesters: arbitrates, issues chunk reads, waits for the result with a watchdog.
module dot_product_scheduler
  import dp_sched_pkg::*;
#(
  parameter int NUM_EQ      = 16,
  parameter int NO_OF_UNITS = 8,
  parameter int ELEM_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        i_req,
  input  logic [ADDR_W-1:0] i_base_a0,
  input  logic [ADDR_W-1:0] i_base_b0,
  input  logic [ADDR_W-1:0] i_base_a1,
  input  logic [ADDR_W-1:0] i_base_b1,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr_a,
  output logic [ADDR_W-1:0] o_mem_addr_b,
  output logic              o_dp_clear,
  output logic              o_dp_valid,
  output logic              o_dp_last,
  input  logic              i_dp_finish,
  input  logic [ELEM_W-1:0] i_dp_result,
  output logic [ELEM_W-1:0] o_result_out,
  output logic              o_result_id,
  output logic [1:0]        o_done,
  output logic              o_busy,
  output logic              o_timeout_err
);

  localparam int CHUNKS = ceil_div(NUM_EQ, NO_OF_UNITS);
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int TW     = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [CW-1:0]     r_chunk;
  logic [TW-1:0]     r_wait_cnt;
  logic [ID_W-1:0]   r_last_grant;
  logic [ID_W-1:0]   r_gnt_id;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic              r_rd_en;
  logic              r_dp_clear;
  logic              r_dp_valid;
  logic              r_dp_last;
  logic              r_timeout_err;
  logic [ELEM_W-1:0] r_result;
  logic [ID_W-1:0]   r_result_id;
  logic [1:0]        r_done;

  logic [1:0]        w_masked_req;
  logic              w_grant_valid;
  logic [ID_W-1:0]   w_grant_id;
  logic              w_last_chunk;
  logic [TW-1:0]     w_wait_next;

  // A requester whose done is pulsing cannot be regranted in the same cycle.
  assign w_masked_req = i_req & ~r_done;
  assign w_last_chunk = (r_chunk == CW'(CHUNKS - 1));
  assign w_wait_next  = r_wait_cnt + TW'(1);

  rr_arbiter_2 u_arb (
    .i_req         (w_masked_req),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_chunk       <= '0;
      r_wait_cnt    <= '0;
      r_last_grant  <= ID_W'(1);
      r_gnt_id      <= '0;
      r_addr_a      <= '0;
      r_addr_b      <= '0;
      r_rd_en       <= 1'b0;
      r_dp_clear    <= 1'b0;
      r_dp_valid    <= 1'b0;
      r_dp_last     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_result      <= '0;
      r_result_id   <= '0;
      r_done        <= 2'b00;
    end else begin
      r_dp_clear <= 1'b0;
      r_done     <= 2'b00;
      r_rd_en    <= 1'b0;
      // Read data arrives one cycle after the strobe, so valid/last trail it by one.
      r_dp_valid <= r_rd_en;
      r_dp_last  <= r_rd_en & w_last_chunk;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_gnt_id   <= w_grant_id;
            r_addr_a   <= (w_grant_id == 1'b1) ? i_base_a1 : i_base_a0;
            r_addr_b   <= (w_grant_id == 1'b1) ? i_base_b1 : i_base_b0;
            r_dp_clear <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_chunk <= '0;
          r_rd_en <= 1'b1;
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (w_last_chunk) begin
            r_wait_cnt <= '0;
            r_state    <= ST_WAIT;
          end else begin
            r_chunk  <= r_chunk + CW'(1);
            r_addr_a <= r_addr_a + ADDR_W'(1);
            r_addr_b <= r_addr_b + ADDR_W'(1);
            r_rd_en  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_dp_finish) begin
            r_result       <= i_dp_result;
            r_result_id    <= r_gnt_id;
            r_done[r_gnt_id] <= 1'b1;
            r_last_grant   <= r_gnt_id;
            r_state        <= ST_IDLE;
          end else if (w_wait_next == TW'(TIMEOUT)) begin
            r_timeout_err    <= 1'b1;
            r_done[r_gnt_id] <= 1'b1;
            r_state          <= ST_IDLE;
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_rd_en   = r_rd_en;
  assign o_mem_addr_a  = r_addr_a;
  assign o_mem_addr_b  = r_addr_b;
  assign o_dp_clear    = r_dp_clear;
  assign o_dp_valid    = r_dp_valid;
  assign o_dp_last     = r_dp_last;
  assign o_result_out  = r_result;
  assign o_result_id   = r_result_id;
  assign o_done        = r_done;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// tb/tb_dot_product_scheduler.sv - directed bench for dot_product_scheduler
// (NUM_EQ=16/TIMEOUT=8 instance plus a NUM_EQ=20 instance on shared inputs).
module tb_dot_product_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [9:0]  base_a0, base_b0, base_a1, base_b1;
  logic        dp_finish;
  logic [31:0] dp_result;

  logic        rd_en, dp_clear, dp_valid, dp_last, result_id, busy, terr;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] result_out;
  logic [1:0]  done;

  logic        rd_en_b, dp_clear_b, dp_valid_b, dp_last_b, result_id_b, busy_b, terr_b;
  logic [9:0]  addr_a_b, addr_b_b;
  logic [31:0] result_out_b;
  logic [1:0]  done_b;

  int n_tests = 0;
  int n_fail  = 0;

  wire [60:0] all_out = {rd_en, addr_a, addr_b, dp_clear, dp_valid, dp_last,
                         result_out, result_id, done, busy, terr};

  dot_product_scheduler #(.NUM_EQ(16), .TIMEOUT(8)) u_dut (
    .clk(clk), .reset(reset), .i_req(req),
    .i_base_a0(base_a0), .i_base_b0(base_b0), .i_base_a1(base_a1), .i_base_b1(base_b1),
    .o_mem_rd_en(rd_en), .o_mem_addr_a(addr_a), .o_mem_addr_b(addr_b),
    .o_dp_clear(dp_clear), .o_dp_valid(dp_valid), .o_dp_last(dp_last),
    .i_dp_finish(dp_finish), .i_dp_result(dp_result),
    .o_result_out(result_out), .o_result_id(result_id), .o_done(done),
    .o_busy(busy), .o_timeout_err(terr)
  );

  dot_product_scheduler #(.NUM_EQ(20)) u_dut20 (
    .clk(clk), .reset(reset), .i_req(req),
    .i_base_a0(base_a0), .i_base_b0(base_b0), .i_base_a1(base_a1), .i_base_b1(base_b1),
    .o_mem_rd_en(rd_en_b), .o_mem_addr_a(addr_a_b), .o_mem_addr_b(addr_b_b),
    .o_dp_clear(dp_clear_b), .o_dp_valid(dp_valid_b), .o_dp_last(dp_last_b),
    .i_dp_finish(dp_finish), .i_dp_result(dp_result),
    .o_result_out(result_out_b), .o_result_id(result_id_b), .o_done(done_b),
    .o_busy(busy_b), .o_timeout_err(terr_b)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 2'b00; dp_finish = 1'b0; dp_result = '0;
    base_a0 = '0; base_b0 = '0; base_a1 = '0; base_b1 = '0;
    step; step;
    n_tests++;
    if (all_out !== 61'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    base_a0 = 10'd4; base_b0 = 10'd20; req = 2'b01;
    step;
    n_tests++;
    if ({dp_clear, busy} !== 2'b11) begin
      n_fail++; $display("FAIL single_clear: got %b want 11", {dp_clear, busy});
    end
    step;
    n_tests++;
    if ({rd_en, addr_a, addr_b, dp_valid} !== {1'b1, 10'd4, 10'd20, 1'b0}) begin
      n_fail++; $display("FAIL single_c2: got %b/%0d/%0d/%b want 1/4/20/0", rd_en, addr_a, addr_b, dp_valid);
    end
    step;
    n_tests++;
    if ({rd_en, addr_a, addr_b, dp_valid, dp_last} !== {1'b1, 10'd5, 10'd21, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL single_c3: got %b/%0d/%0d/%b/%b want 1/5/21/1/0", rd_en, addr_a, addr_b, dp_valid, dp_last);
    end
    step;
    n_tests++;
    if ({rd_en, dp_valid, dp_last} !== 3'b011) begin
      n_fail++; $display("FAIL single_c4: got %b want 011", {rd_en, dp_valid, dp_last});
    end
    for (int c = 5; c <= 9; c++) begin
      step;
      if (c == 9) begin dp_finish = 1'b1; dp_result = 32'h40490FDB; end
      n_tests++;
      if ({done, dp_valid} !== 3'b000) begin
        n_fail++; $display("FAIL single_quiet c%0d: got %b want 000", c, {done, dp_valid});
      end
    end
    step;
    dp_finish = 1'b0;
    n_tests++;
    if ({done, result_id, result_out} !== {2'b01, 1'b0, 32'h40490FDB}) begin
      n_fail++; $display("FAIL single_done: got %b/%b/%h want 01/0/40490fdb", done, result_id, result_out);
    end
    req = 2'b00;
    step;
    n_tests++;
    if ({done, busy} !== 3'b000) begin
      n_fail++; $display("FAIL single_idle: got %b want 000", {done, busy});
    end
  endtask

  task automatic test_wrap;
    base_a1 = 10'd1023; base_b1 = 10'd1000; req = 2'b10;
    step; step;
    n_tests++;
    if ({rd_en, addr_a, addr_b} !== {1'b1, 10'd1023, 10'd1000}) begin
      n_fail++; $display("FAIL wrap_c2: got %b/%0d/%0d want 1/1023/1000", rd_en, addr_a, addr_b);
    end
    step;
    n_tests++;
    if ({rd_en, addr_a, addr_b} !== {1'b1, 10'd0, 10'd1001}) begin
      n_fail++; $display("FAIL wrap_c3: got %b/%0d/%0d want 1/0/1001", rd_en, addr_a, addr_b);
    end
    step;
    dp_finish = 1'b1; dp_result = 32'h0000ABCD;
    step;
    dp_finish = 1'b0;
    n_tests++;
    if ({done, result_id, result_out} !== {2'b10, 1'b1, 32'h0000ABCD}) begin
      n_fail++; $display("FAIL wrap_done: got %b/%b/%h want 10/1/0000abcd", done, result_id, result_out);
    end
    req = 2'b00;
    step;
  endtask

  task automatic test_contention;
    int budget;
    logic [1:0] exp_done;
    reset = 1'b1; step; reset = 1'b0;
    base_a0 = 10'd0; base_b0 = 10'd0; base_a1 = 10'd100; base_b1 = 10'd200;
    req = 2'b11;
    for (int op = 0; op < 4; op++) begin
      budget = 0;
      do begin step; budget++; end while (dp_last !== 1'b1 && budget < 20);
      n_tests++;
      if (dp_last !== 1'b1 || addr_a !== ((op % 2 == 1) ? 10'd101 : 10'd1)) begin
        n_fail++; $display("FAIL contention_owner op%0d: got last=%b addr_a=%0d want last=1 addr_a=%0d",
                           op, dp_last, addr_a, (op % 2 == 1) ? 101 : 1);
      end
      step;
      dp_finish = 1'b1; dp_result = 32'h100 + op;
      step;
      dp_finish = 1'b0;
      exp_done = (op % 2 == 1) ? 2'b10 : 2'b01;
      n_tests++;
      if ({done, result_id, result_out} !== {exp_done, exp_done[1], 32'h100 + op}) begin
        n_fail++; $display("FAIL contention_done op%0d: got %b/%b/%h want %b/%b/%h",
                           op, done, result_id, result_out, exp_done, exp_done[1], 32'h100 + op);
      end
      if (op == 3) req = 2'b00;
      step;
      n_tests++;
      if (dp_clear !== (op < 3)) begin
        n_fail++; $display("FAIL contention_regrant op%0d: got clear=%b want %b", op, dp_clear, op < 3);
      end
    end
  endtask

  task automatic test_timeout;
    int budget;
    base_a0 = 10'd8; base_b0 = 10'd8; req = 2'b01;
    for (int c = 1; c <= 11; c++) begin
      step;
      n_tests++;
      if (done !== 2'b00) begin
        n_fail++; $display("FAIL timeout_early c%0d: got done=%b want 00", c, done);
      end
    end
    step;
    n_tests++;
    if ({done, terr, result_id, result_out} !== {2'b01, 1'b1, 1'b1, 32'h103}) begin
      n_fail++; $display("FAIL timeout_fire: got %b/%b/%b/%h want 01/1/1/00000103", done, terr, result_id, result_out);
    end
    req = 2'b00;
    step; step;
    n_tests++;
    if ({terr, busy} !== 2'b10) begin
      n_fail++; $display("FAIL timeout_sticky: got %b want 10", {terr, busy});
    end
    base_a1 = 10'd50; req = 2'b10;
    budget = 0;
    do begin step; budget++; end while (dp_last !== 1'b1 && budget < 20);
    step;
    dp_finish = 1'b1; dp_result = 32'h00005555;
    step;
    dp_finish = 1'b0;
    n_tests++;
    if ({done, terr, result_out} !== {2'b10, 1'b1, 32'h00005555}) begin
      n_fail++; $display("FAIL timeout_recover: got %b/%b/%h want 10/1/00005555", done, terr, result_out);
    end
    req = 2'b00;
    step;
  endtask

  task automatic test_midop_reset;
    req = 2'b01;
    step; step;
    reset = 1'b1; req = 2'b00;
    step;
    reset = 1'b0; dp_finish = 1'b1; dp_result = 32'hDEADBEEF;
    for (int c = 3; c <= 7; c++) begin
      n_tests++;
      if (all_out !== 61'd0) begin
        n_fail++; $display("FAIL midop_reset c%0d: got %h want 0", c, all_out);
      end
      step;
      dp_finish = 1'b0;
    end
  endtask

  task automatic test_nonmultiple;
    int vcnt, lcnt, first, lastc;
    vcnt = 0; lcnt = 0; first = -1; lastc = -1;
    reset = 1'b1; step; reset = 1'b0;
    base_a0 = 10'd0; base_b0 = 10'd0; req = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      step;
      if (dp_valid_b === 1'b1) begin vcnt++; if (first < 0) first = c; end
      if (dp_last_b === 1'b1) begin lcnt++; lastc = c; end
      if (c == 4) begin
        n_tests++;
        if ({rd_en_b, addr_a_b} !== {1'b1, 10'd2}) begin
          n_fail++; $display("FAIL nonmult_addr: got %b/%0d want 1/2", rd_en_b, addr_a_b);
        end
      end
    end
    n_tests++;
    if (vcnt != 3 || first != 3) begin
      n_fail++; $display("FAIL nonmult_valid: got count=%0d first=%0d want count=3 first=3", vcnt, first);
    end
    n_tests++;
    if (lcnt != 1 || lastc != 5) begin
      n_fail++; $display("FAIL nonmult_last: got count=%0d cycle=%0d want count=1 cycle=5", lcnt, lastc);
    end
    dp_finish = 1'b1; dp_result = 32'h00000020;
    step;
    dp_finish = 1'b0;
    n_tests++;
    if ({done_b, result_out_b} !== {2'b01, 32'h00000020}) begin
      n_fail++; $display("FAIL nonmult_done: got %b/%h want 01/00000020", done_b, result_out_b);
    end
    req = 2'b00;
    step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_contention;
    test_timeout;
    test_midop_reset;
    test_nonmultiple;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
